bram_slot_ctrl: RTL
===================

# bram_slot_ctrl

Parametrised save-slot controller that moves backup-RAM contents between the core's on-chip backup RAM (port B) and the HPS SD sector interface. It generalises the fixed 4-slot / 16-sector save logic: slot count and sectors per slot are parameters, and it adds a local format engine, dirty tracking with autosave, and an SD handshake timeout. It sits in the top-level emu wrapper, between `hps_io` and the backup RAM dual-port memories.

## Interface
- `SLOT_W`, 2: slot index width; slot count is 2^SLOT_W.
- `SECT_W`, 4: sector index width; sectors per slot is 2^SECT_W.
- `BUF_AW`, 8: sector buffer word address width; 2^BUF_AW 16-bit words per sector.
- `TIMEOUT`, 2^22: cycles allowed per SD handshake phase.
- `clk_sys`  in  1: system clock.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  1: writable save image mounted.
- `slot`  in  SLOT_W: target slot, sampled at request accept.
- `load_req`, `save_req`, `format_req`  in  1 each: level inputs; a rising edge is a request.
- `autosave_tick`  in  1: single-cycle pulse.
- `autosave_en`  in  1: autosave enable.
- `bram_we`  in  1: core write strobe to the backup RAM.
- `sd_lba`  out  32: sector address.
- `sd_rd`, `sd_wr`  out  1 each: HPS sector request.
- `sd_ack`  in  1: HPS acknowledge.
- `sd_buff_addr`  in  BUF_AW: buffer word address.
- `sd_buff_dout`  in  16: buffer write data.
- `sd_buff_wr`  in  1: buffer write strobe.
- `ram_addr`  out  SECT_W+BUF_AW: backup RAM port B address.
- `ram_din`  out  16: backup RAM port B write data.
- `ram_we`  out  1: backup RAM port B write enable.
- `busy`  out  1: any operation in progress.
- `loading`  out  1: load in progress; holds the core in reset.
- `dirty`  out  1: RAM differs from the last saved or loaded image.
- `err`  out  1: last operation timed out.

## Operation
- States: IDLE, REQ, XFER, FMT.
- Edge detection uses registered previous values of the three request inputs and `sd_ack`.
- **Accept from IDLE.**
  - Load or save edge with `enable=1`: priority load > save > format.
  - Autosave: `autosave_tick & autosave_en & dirty & enable` starts a save. Lowest priority.
  - Format edge: accepted regardless of `enable`.
  - On accept: latch `slot`, set sector=0, clear `err`.
  - Edges arriving while busy are dropped, not queued.
- **REQ** (load/save):
  - `sd_lba` = zero-extended {slot, sector}.
  - Assert `sd_rd` (load) or `sd_wr` (save).
  - On `sd_ack` rising edge: deassert request, go to XFER.
- **XFER**:
  - On `sd_ack` falling edge: if sector is all-ones, go to IDLE. Otherwise sector+1 and go to REQ.
  - On completion clear `dirty`, and `loading` for a load.
- **Port B mux**:
  - `ram_addr` = {sector, sd_buff_addr}.
  - `ram_din` = `sd_buff_dout`.
  - `ram_we` = `sd_buff_wr & sd_ack & loading`.
  - Save data is read back externally from port B `q`.
- **FMT**:
  - Counter walks addresses 0..2^(SECT_W+BUF_AW)-1, one word per cycle, `ram_we`=1.
  - Words 0..3 = 0x5548, 0x4D42, 0x8800, 0x8010. All other words = 0.
  - Then return to IDLE with `dirty`=1. No SD traffic.
- **Dirty**: set by `bram_we`. A set in the same cycle as a clear wins.
- **Timeout**:
  - Counter clears on every REQ/XFER entry.
  - On reaching TIMEOUT-1: drop `sd_rd`/`sd_wr`, set `err`, clear `loading`, return to IDLE.
  - `dirty` is unchanged by a timeout.

## Timing
- Reset values: `sd_lba`, `sd_rd`, `sd_wr`, `ram_we` (FMT term), `busy`, `loading`, `dirty`, `err` all 0.
- A reset mid-operation aborts immediately to IDLE.
- Request input rises in cycle N: `busy`, `loading` and `sd_rd`/`sd_wr` are high from N+2, after the input register and edge register.
- `sd_rd`/`sd_wr` low in the cycle after the ack rise is registered.
- The next sector request is issued 1 cycle after the ack fall is registered.
- Format takes exactly 2^(SECT_W+BUF_AW) write cycles; `busy` falls the cycle after the last write.
- `sd_lba` is stable for the whole REQ/XFER of a sector.

## Structure
- Package `bram_slot_pkg`:
  - State enum.
  - Format header constant array (4 x 16-bit).
  - Helper for LBA width.
- Sub-module `sd_req_timer`: loadable down-counter with expire pulse, parametrised by TIMEOUT.
- Everything else lives in one module.

## Test plan
- Save, slot=2, defaults, HPS model acks each request after 5 cycles: 16 requests with `sd_lba` 0x20..0x2F, `sd_wr` only, `dirty` 1→0, `busy` falls after the 16th ack.
- Load, slot=1, model writes pattern (addr ^ lba): `loading` high throughout, RAM[sector*256+a] matches, `sd_lba` 0x10..0x1F, `dirty`=0 at end.
- Format with `enable`=0: 4096 `ram_we` cycles; words 0..3 = 0x5548/0x4D42/0x8800/0x8010, word 4 = 0; `dirty`=1; `sd_rd`/`sd_wr` never assert.
- Simultaneous load and save edges: load performed. A save edge arriving mid-load is ignored, giving exactly 16 requests.
- TIMEOUT=64, model never acks: `sd_rd` drops at 64 cycles, `err`=1, `loading`=0. The next accepted save clears `err`.
- Autosave: `bram_we` pulse then `autosave_tick` with `autosave_en`=1 starts a save. A `bram_we` during the final ack fall leaves `dirty`=1. `reset` mid-transfer zeroes all outputs next cycle.

Source files
------------

// File: rtl/bram_slot_pkg.sv
// Shared types and constants for the backup-RAM save-slot controller.
package bram_slot_pkg;

  // Controller states: idle, sector request pending, sector transfer, local format
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_FMT
  } slot_state_t;

  // Blank-image header written to words 0..3 by the format engine
  localparam int FMT_HDR_N = 4;
  localparam logic [FMT_HDR_N-1:0][15:0] FMT_HDR = {16'h8010, 16'h8800, 16'h4D42, 16'h5548};

  // Width of the {slot, sector} part of the SD sector address
  function automatic int lba_width(input int slot_w, input int sect_w);
    return slot_w + sect_w;
  endfunction

endpackage

// File: rtl/sd_req_timer.sv
// Loadable down-counter guarding one SD handshake phase; expire is high for
// the cycle in which TIMEOUT cycles of the phase have elapsed.
module sd_req_timer #(
  parameter int TIMEOUT = 4194304
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_reg;

  // Reload at phase entry, then count down while the phase is active
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= RELOAD;
    end else if (run && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CW'(1);
    end
  end

  assign expire = run && (cnt_reg == '0);

endmodule

// File: rtl/bram_slot_ctrl.sv
// Save-slot controller: streams backup RAM between port B and the HPS SD
// sector interface, formats a blank image locally, tracks dirty state and
// autosaves, and abandons a handshake that stalls.
module bram_slot_ctrl
  import bram_slot_pkg::*;
#(
  parameter int SLOT_W  = 2,
  parameter int SECT_W  = 4,
  parameter int BUF_AW  = 8,
  parameter int TIMEOUT = 4194304
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [SLOT_W-1:0]        slot,
  input  logic                     load_req,
  input  logic                     save_req,
  input  logic                     format_req,
  input  logic                     autosave_tick,
  input  logic                     autosave_en,
  input  logic                     bram_we,
  output logic [31:0]              sd_lba,
  output logic                     sd_rd,
  output logic                     sd_wr,
  input  logic                     sd_ack,
  input  logic [BUF_AW-1:0]        sd_buff_addr,
  input  logic [15:0]              sd_buff_dout,
  input  logic                     sd_buff_wr,
  output logic [SECT_W+BUF_AW-1:0] ram_addr,
  output logic [15:0]              ram_din,
  output logic                     ram_we,
  output logic                     busy,
  output logic                     loading,
  output logic                     dirty,
  output logic                     err
);

  localparam int LBA_W  = lba_width(SLOT_W, SECT_W);
  localparam int RAM_AW = SECT_W + BUF_AW;
  localparam int N_REQ  = 3;

  slot_state_t         state_reg;
  logic [SLOT_W-1:0]   slot_reg;
  logic [SECT_W-1:0]   sector_reg;
  logic [RAM_AW-1:0]   fmt_cnt_reg;
  logic                op_load_reg;
  logic                sd_rd_reg, sd_wr_reg;
  logic                busy_reg, loading_reg, dirty_reg, err_reg;
  logic                ack_sync_reg, ack_prev_reg;

  // Request bit order: 0 = load, 1 = save, 2 = format
  logic [N_REQ-1:0] req_in;
  logic [N_REQ-1:0] req_edge;
  assign req_in = {format_req, save_req, load_req};

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req_edge
      logic sync_reg;
      logic prev_reg;
      // Register the request level and its previous value for edge detection
      always_ff @(posedge clk_sys) begin
        if (reset) begin
          sync_reg <= 1'b0;
          prev_reg <= 1'b0;
        end else begin
          sync_reg <= req_in[gi];
          prev_reg <= sync_reg;
        end
      end
      assign req_edge[gi] = sync_reg & ~prev_reg;
    end
  endgenerate

  // Register the HPS acknowledge and its previous value for edge detection
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ack_sync_reg <= 1'b0;
      ack_prev_reg <= 1'b0;
    end else begin
      ack_sync_reg <= sd_ack;
      ack_prev_reg <= ack_sync_reg;
    end
  end

  logic ack_rise, ack_fall;
  assign ack_rise = ack_sync_reg & ~ack_prev_reg;
  assign ack_fall = ~ack_sync_reg & ack_prev_reg;

  // Accept decode from IDLE: load > save > format > autosave
  logic is_idle, start_ld, start_sv, start_fm, start_as, start_sd;
  assign is_idle  = (state_reg == ST_IDLE);
  assign start_ld = req_edge[0] & enable;
  assign start_sv = ~start_ld & req_edge[1] & enable;
  assign start_fm = ~start_ld & ~start_sv & req_edge[2];
  assign start_as = ~start_ld & ~start_sv & ~start_fm &
                    autosave_tick & autosave_en & dirty_reg & enable;
  assign start_sd = start_ld | start_sv | start_as;

  logic sector_last, fmt_last, expire;
  logic timer_load, timer_run, xfer_done, fmt_done;
  assign sector_last = &sector_reg;
  assign fmt_last    = &fmt_cnt_reg;
  assign timer_run   = (state_reg == ST_REQ) || (state_reg == ST_XFER);
  assign timer_load  = (is_idle && start_sd) ||
                       ((state_reg == ST_REQ)  && !expire && ack_rise) ||
                       ((state_reg == ST_XFER) && !expire && ack_fall && !sector_last);
  assign xfer_done   = (state_reg == ST_XFER) && !expire && ack_fall && sector_last;
  assign fmt_done    = (state_reg == ST_FMT) && fmt_last;

  sd_req_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_sys (clk_sys),
    .reset   (reset),
    .load    (timer_load),
    .run     (timer_run),
    .expire  (expire)
  );

  // Main sequencer with registered handshake and status outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      slot_reg    <= '0;
      sector_reg  <= '0;
      fmt_cnt_reg <= '0;
      op_load_reg <= 1'b0;
      sd_rd_reg   <= 1'b0;
      sd_wr_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      loading_reg <= 1'b0;
      dirty_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      // A core write landing in the same cycle as a completion keeps the image dirty
      if (bram_we || fmt_done) begin
        dirty_reg <= 1'b1;
      end else if (xfer_done) begin
        dirty_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (start_sd || start_fm) begin
            slot_reg    <= slot;
            sector_reg  <= '0;
            err_reg     <= 1'b0;
            busy_reg    <= 1'b1;
            fmt_cnt_reg <= '0;
          end
          if (start_sd) begin
            state_reg   <= ST_REQ;
            op_load_reg <= start_ld;
            loading_reg <= start_ld;
            sd_rd_reg   <= start_ld;
            sd_wr_reg   <= ~start_ld;
          end else if (start_fm) begin
            state_reg   <= ST_FMT;
            op_load_reg <= 1'b0;
          end
        end

        ST_REQ: begin
          if (expire) begin
            state_reg   <= ST_IDLE;
            sd_rd_reg   <= 1'b0;
            sd_wr_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            loading_reg <= 1'b0;
            err_reg     <= 1'b1;
          end else if (ack_rise) begin
            state_reg <= ST_XFER;
            sd_rd_reg <= 1'b0;
            sd_wr_reg <= 1'b0;
          end
        end

        ST_XFER: begin
          if (expire) begin
            state_reg   <= ST_IDLE;
            busy_reg    <= 1'b0;
            loading_reg <= 1'b0;
            err_reg     <= 1'b1;
          end else if (ack_fall) begin
            if (sector_last) begin
              state_reg   <= ST_IDLE;
              busy_reg    <= 1'b0;
              loading_reg <= 1'b0;
            end else begin
              state_reg  <= ST_REQ;
              sector_reg <= sector_reg + 1'b1;
              sd_rd_reg  <= op_load_reg;
              sd_wr_reg  <= ~op_load_reg;
            end
          end
        end

        ST_FMT: begin
          if (fmt_last) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            fmt_cnt_reg <= fmt_cnt_reg + 1'b1;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // SD address is built from registered slot/sector, so it holds for a whole sector
  logic [LBA_W-1:0] lba_cur;
  assign lba_cur = {slot_reg, sector_reg};
  assign sd_lba  = 32'(lba_cur);
  assign sd_rd   = sd_rd_reg;
  assign sd_wr   = sd_wr_reg;

  // Port B: format engine owns the port while formatting, otherwise the SD buffer
  logic        fmt_active;
  logic [15:0] fmt_word;
  assign fmt_active = (state_reg == ST_FMT);
  assign fmt_word   = (fmt_cnt_reg[RAM_AW-1:2] == '0) ? FMT_HDR[fmt_cnt_reg[1:0]] : 16'h0000;
  assign ram_addr   = fmt_active ? fmt_cnt_reg : {sector_reg, sd_buff_addr};
  assign ram_din    = fmt_active ? fmt_word : sd_buff_dout;
  assign ram_we     = fmt_active | (sd_buff_wr & sd_ack & loading_reg);

  assign busy    = busy_reg;
  assign loading = loading_reg;
  assign dirty   = dirty_reg;
  assign err     = err_reg;

endmodule
